// File: rtl/rr_arbiter.sv
// Registered N-way arbiter: fixed-priority or round-robin selection, grant hold
// until request drop or acknowledge, optional max-hold preemption.
module rr_arbiter #(
    parameter int unsigned PORTS                 = 4,
    parameter int unsigned ARB_ROUND_ROBIN       = 1,
    parameter int unsigned ARB_BLOCK             = 1,
    parameter int unsigned ARB_BLOCK_ACK         = 0,
    parameter int unsigned ARB_LSB_HIGH_PRIORITY = 1,
    parameter int unsigned MAX_HOLD              = 0,
    localparam int unsigned IDX_W                = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] request,
    input  logic [PORTS-1:0] acknowledge,
    output logic [PORTS-1:0] grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_encoded
);

    localparam int unsigned CNT_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int unsigned HOLD_MAX = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam int unsigned LAST_RST = (ARB_LSB_HIGH_PRIORITY != 0) ? PORTS - 1 : 0;

    logic [PORTS-1:0] grant_q, grant_d;
    logic             grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0] grant_encoded_q, grant_encoded_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic             req_granted;
    logic             ack_granted;
    logic             others_req;
    logic             preempt;
    logic             release_g;
    logic [PORTS-1:0] cand;
    logic [PORTS-1:0] rr_mask;
    logic [PORTS-1:0] cand_masked;
    logic [IDX_W-1:0] win_idx;

    // Priority encoder; tie polarity follows ARB_LSB_HIGH_PRIORITY.
    function automatic logic [IDX_W-1:0] prio_enc(input logic [PORTS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        if (ARB_LSB_HIGH_PRIORITY != 0) begin
            for (int i = PORTS - 1; i >= 0; i--) begin
                if (v[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < PORTS; i++) begin
                if (v[i]) idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Release decision and winner selection for the next edge.
    always_comb begin
        req_granted = |(request & grant_q);
        ack_granted = |(acknowledge & grant_q);
        others_req  = |(request & ~grant_q);

        preempt = (ARB_BLOCK != 0) && (MAX_HOLD > 0) && grant_valid_q && others_req &&
                  (hold_cnt_q == CNT_W'(HOLD_MAX));

        if (ARB_BLOCK == 0) begin
            release_g = 1'b1;
        end else if (ARB_BLOCK_ACK != 0) begin
            release_g = ack_granted;
        end else begin
            release_g = !req_granted;
        end
        release_g = release_g || preempt;

        // A preempted holder sits out this one arbitration.
        cand = preempt ? (request & ~grant_q) : request;

        for (int i = 0; i < PORTS; i++) begin
            if (ARB_LSB_HIGH_PRIORITY != 0) begin
                rr_mask[i] = (IDX_W'(i) > last_q);
            end else begin
                rr_mask[i] = (IDX_W'(i) < last_q);
            end
        end
        cand_masked = cand & rr_mask;

        if ((ARB_ROUND_ROBIN != 0) && (|cand_masked)) begin
            win_idx = prio_enc(cand_masked);
        end else begin
            win_idx = prio_enc(cand);
        end
    end

    // Next-state: hold, register a new winner, or go idle.
    always_comb begin
        grant_d         = grant_q;
        grant_valid_d   = grant_valid_q;
        grant_encoded_d = grant_encoded_q;
        last_d          = last_q;
        hold_cnt_d      = hold_cnt_q;

        if (grant_valid_q && !release_g) begin
            if (others_req && (hold_cnt_q != CNT_W'(HOLD_MAX))) begin
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end else if (!others_req) begin
                hold_cnt_d = '0;
            end
        end else if (|request) begin
            grant_d         = PORTS'(1) << win_idx;
            grant_valid_d   = 1'b1;
            grant_encoded_d = win_idx;
            last_d          = win_idx;
            hold_cnt_d      = '0;
        end else begin
            grant_d         = '0;
            grant_valid_d   = 1'b0;
            grant_encoded_d = '0;
            hold_cnt_d      = '0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q         <= '0;
            grant_valid_q   <= 1'b0;
            grant_encoded_q <= '0;
            last_q          <= IDX_W'(LAST_RST);
            hold_cnt_q      <= '0;
        end else begin
            grant_q         <= grant_d;
            grant_valid_q   <= grant_valid_d;
            grant_encoded_q <= grant_encoded_d;
            last_q          <= last_d;
            hold_cnt_q      <= hold_cnt_d;
        end
    end

    assign grant         = grant_q;
    assign grant_valid   = grant_valid_q;
    assign grant_encoded = grant_encoded_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: several configurations side by side,
// directed vector table, reset-mid-grant sequence, random stress against a model.
module tb_rr_arbiter;

    localparam int P  = 4;
    localparam int NI = 5;
    // Instance configurations: 0 RR/block, 1 fixed/no-block, 2 RR/ack,
    // 3 fixed/block/max-hold 3, 4 RR MSB-high/ack/max-hold 2.
    localparam int CFG_RR  [NI] = '{1, 0, 1, 0, 1};
    localparam int CFG_BLK [NI] = '{1, 0, 1, 1, 1};
    localparam int CFG_ACK [NI] = '{0, 0, 1, 0, 1};
    localparam int CFG_LSB [NI] = '{1, 1, 1, 1, 0};
    localparam int CFG_MH  [NI] = '{0, 0, 0, 3, 2};

    logic         clk = 1'b0;
    logic         rst;
    logic [P-1:0] req  [NI];
    logic [P-1:0] ack  [NI];
    logic [P-1:0] gnt  [NI];
    logic         gv   [NI];
    logic [1:0]   genc [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        rr_arbiter #(
            .PORTS                (P),
            .ARB_ROUND_ROBIN      (CFG_RR[k]),
            .ARB_BLOCK            (CFG_BLK[k]),
            .ARB_BLOCK_ACK        (CFG_ACK[k]),
            .ARB_LSB_HIGH_PRIORITY(CFG_LSB[k]),
            .MAX_HOLD             (CFG_MH[k])
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .request      (req[k]),
            .acknowledge  (ack[k]),
            .grant        (gnt[k]),
            .grant_valid  (gv[k]),
            .grant_encoded(genc[k])
        );
    end

    // ---------------- reference model (port indices, -1 = idle) ----------------
    int m_g    [NI];
    int m_last [NI];
    int m_cnt  [NI];
    bit m_new  [NI];

    // Walk the ports in priority order starting just after the last winner.
    function automatic int choose(int k, logic [P-1:0] v);
        for (int n = 1; n <= P; n++) begin
            int p;
            if (CFG_RR[k] != 0) p = (CFG_LSB[k] != 0) ? (m_last[k] + n) % P : (m_last[k] - n + 2 * P) % P;
            else                p = (CFG_LSB[k] != 0) ? n - 1 : P - n;
            if (v[p]) return p;
        end
        return -1;
    endfunction

    function automatic void model_step(int k, logic r, logic [P-1:0] rq, logic [P-1:0] ak);
        int g;
        logic [P-1:0] others;
        bit pre, rel;
        g = m_g[k];
        m_new[k] = 1'b0;
        if (r) begin
            m_g[k] = -1; m_last[k] = (CFG_LSB[k] != 0) ? P - 1 : 0; m_cnt[k] = 0;
            return;
        end
        others = rq;
        if (g >= 0) others[g] = 1'b0;
        pre = (g >= 0) && (CFG_BLK[k] != 0) && (CFG_MH[k] > 0) && (m_cnt[k] == CFG_MH[k] - 1) && (others != 0);
        rel = 1'b1;
        if (g >= 0) begin
            if (CFG_BLK[k] == 0)      rel = 1'b1;
            else if (CFG_ACK[k] != 0) rel = ak[g];
            else                      rel = !rq[g];
            rel = rel || pre;
        end
        if (g >= 0 && !rel) begin
            if (others != 0 && CFG_MH[k] > 0) m_cnt[k] = (m_cnt[k] + 1 < CFG_MH[k]) ? m_cnt[k] + 1 : CFG_MH[k] - 1;
            else                              m_cnt[k] = 0;
        end else if (rq != 0) begin
            m_g[k] = choose(k, pre ? others : rq);
            m_last[k] = m_g[k]; m_cnt[k] = 0; m_new[k] = 1'b1;
        end else begin
            m_g[k] = -1; m_cnt[k] = 0;
        end
    endfunction

    // ---------------- comparison helpers ----------------
    task automatic check_vals(string nm, int k, logic [P-1:0] eg, logic [1:0] ee);
        checks++;
        if (gnt[k] !== eg || gv[k] !== (|eg) || genc[k] !== ee) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: grant=%b valid=%b enc=%0d, expected grant=%b valid=%b enc=%0d",
                     nm, k, $time, gnt[k], gv[k], genc[k], eg, |eg, ee);
        end
    endtask

    task automatic check_model(int k);
        logic [P-1:0] eg;
        eg = '0;
        if (m_g[k] >= 0) eg[m_g[k]] = 1'b1;
        check_vals("model", k, eg, (m_g[k] >= 0) ? 2'(m_g[k]) : 2'd0);
    endtask

    task automatic check_inv(int k);
        bit ok;
        ok = ($countones(gnt[k]) <= 1) && (gv[k] == (|gnt[k]));
        if (gv[k] && !gnt[k][genc[k]]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL invariant dut%0d t=%0t: grant=%b valid=%b enc=%0d", k, $time, gnt[k], gv[k], genc[k]);
        end
    endtask

    task automatic apply(int k, logic r, logic [P-1:0] rq, logic [P-1:0] ak);
        rst = r; req[k] = rq; ack[k] = ak;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int           k;
        logic         r;
        logic [P-1:0] rq;
        logic [P-1:0] ak;
        logic [P-1:0] eg;
        logic [1:0]   ee;
        string        nm;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(int k, logic [P-1:0] rq, logic [P-1:0] ak, logic [P-1:0] eg, logic [1:0] ee, string nm);
        vec_t v;
        v.k = k; v.r = 1'b0; v.rq = rq; v.ak = ak; v.eg = eg; v.ee = ee; v.nm = nm;
        tbl.push_back(v);
    endfunction

    logic [P-1:0] snap_g [NI];
    logic         snap_v [NI];
    logic [1:0]   snap_e [NI];
    int           wait_n [P];

    initial begin
        // round-robin rotation with each holder dropping its request
        add(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, "rr_first");
        add(0, 4'b1110, 4'b0000, 4'b0010, 2'd1, "rr_p1");
        add(0, 4'b1101, 4'b0000, 4'b0100, 2'd2, "rr_p2");
        add(0, 4'b1011, 4'b0000, 4'b1000, 2'd3, "rr_p3");
        add(0, 4'b0111, 4'b0000, 4'b0001, 2'd0, "rr_wrap");
        add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, "rr_idle");
        // fixed priority, re-arbitrate every cycle
        add(1, 4'b1010, 4'b0000, 4'b0010, 2'd1, "fx_1010");
        add(1, 4'b1011, 4'b0000, 4'b0001, 2'd0, "fx_1011");
        add(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, "fx_idle");
        // acknowledge-based release
        add(2, 4'b0100, 4'b0000, 4'b0100, 2'd2, "ack_grant2");
        add(2, 4'b0000, 4'b0000, 4'b0100, 2'd2, "ack_drop_held");
        add(2, 4'b0000, 4'b0010, 4'b0100, 2'd2, "ack_other_ign");
        add(2, 4'b0001, 4'b0100, 4'b0001, 2'd0, "ack_release");
        add(2, 4'b0001, 4'b0000, 4'b0001, 2'd0, "ack_hold_noack");
        add(2, 4'b0000, 4'b0001, 4'b0000, 2'd0, "ack_drop_and_ack");
        // max-hold preemption, ports 0 and 3 alternate every 3 cycles
        add(3, 4'b0001, 4'b0000, 4'b0001, 2'd0, "mh_c0");
        add(3, 4'b1001, 4'b0000, 4'b0001, 2'd0, "mh_c1");
        add(3, 4'b1001, 4'b0000, 4'b0001, 2'd0, "mh_c2");
        add(3, 4'b1001, 4'b0000, 4'b1000, 2'd3, "mh_pre3");
        add(3, 4'b1001, 4'b0000, 4'b1000, 2'd3, "mh_c4");
        add(3, 4'b1001, 4'b0000, 4'b1000, 2'd3, "mh_c5");
        add(3, 4'b1001, 4'b0000, 4'b0001, 2'd0, "mh_pre0");
        add(3, 4'b1001, 4'b0000, 4'b0001, 2'd0, "mh_c7");
        add(3, 4'b1001, 4'b0000, 4'b0001, 2'd0, "mh_c8");
        add(3, 4'b1001, 4'b0000, 4'b1000, 2'd3, "mh_pre3b");
        add(3, 4'b0000, 4'b0000, 4'b0000, 2'd0, "mh_idle");
        // MSB-high round-robin with acknowledge
        add(4, 4'b1111, 4'b0000, 4'b1000, 2'd3, "msb_first");
        add(4, 4'b1111, 4'b1000, 4'b0100, 2'd2, "msb_next");
        add(4, 4'b0000, 4'b0100, 4'b0000, 2'd0, "msb_idle");

        // reset state
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin req[k] = '0; ack[k] = '0; end
        apply(0, 1'b1, 4'b0000, 4'b0000);
        apply(0, 1'b1, 4'b0000, 4'b0000);
        for (int k = 0; k < NI; k++) check_vals("reset", k, 4'b0000, 2'd0);

        foreach (tbl[i]) begin
            apply(tbl[i].k, tbl[i].r, tbl[i].rq, tbl[i].ak);
            check_vals(tbl[i].nm, tbl[i].k, tbl[i].eg, tbl[i].ee);
        end

        // reset in the middle of a held grant clears the round-robin pointer too
        apply(0, 1'b0, 4'b0100, 4'b0000); check_vals("mid_grant", 0, 4'b0100, 2'd2);
        apply(0, 1'b0, 4'b1101, 4'b0000); check_vals("mid_held", 0, 4'b0100, 2'd2);
        apply(0, 1'b1, 4'b1101, 4'b0000); check_vals("mid_reset", 0, 4'b0000, 2'd0);
        apply(0, 1'b0, 4'b1101, 4'b0000); check_vals("post_reset", 0, 4'b0001, 2'd0);

        // random stress against the model
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin req[k] = '0; ack[k] = '0; end
        @(posedge clk);
        for (int k = 0; k < NI; k++) model_step(k, 1'b1, '0, '0);
        for (int p = 0; p < P; p++) wait_n[p] = 0;
        #1;
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < NI; k++) begin
                check_model(k);
                check_inv(k);
                snap_g[k] = gnt[k]; snap_v[k] = gv[k]; snap_e[k] = genc[k];
            end
            rst = ($urandom_range(0, 255) == 0);
            for (int k = 0; k < NI; k++) begin
                req[k] = 4'($urandom_range(0, 15));
                ack[k] = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            end
            #3;
            for (int k = 0; k < NI; k++) begin
                checks++;
                if (gnt[k] !== snap_g[k] || gv[k] !== snap_v[k] || genc[k] !== snap_e[k]) begin
                    errors++;
                    $display("FAIL stable dut%0d t=%0t: grant=%b changed from %b between edges", k, $time, gnt[k], snap_g[k]);
                end
            end
            @(posedge clk);
            for (int k = 0; k < NI; k++) model_step(k, rst, req[k], ack[k]);
            // starvation bound on the round-robin instance
            for (int p = 0; p < P; p++) begin
                if (rst || !req[0][p] || m_g[0] == p) begin
                    wait_n[p] = 0;
                end else if (m_new[0]) begin
                    wait_n[p]++;
                    checks++;
                    if (wait_n[p] > P - 1) begin
                        errors++;
                        $display("FAIL starve port%0d t=%0t: %0d grants to others, limit %0d", p, $time, wait_n[p], P - 1);
                    end
                end
            end
            #1;
        end
        for (int k = 0; k < NI; k++) check_model(k);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Registered N-way arbiter that shares one downstream resource (bus, FIFO write port, DMA engine) between PORTS requesters.
- Built around the team's combinational priority encoder. It supplies fixed-priority or round-robin selection, grant hold until request drop or acknowledge, and an optional maximum-hold preemption counter.
- Output is one-hot grant plus encoded index, used by muxes and interconnect.

Parameters:
- PORTS, 4, number of requesters (>=2).
- ARB_ROUND_ROBIN, 1, 1 = round-robin, 0 = fixed priority.
- ARB_BLOCK, 1, 1 = hold grant per the release rule below, 0 = re-arbitrate every cycle.
- ARB_BLOCK_ACK, 0, with ARB_BLOCK=1: 1 = release on acknowledge, 0 = release when request drops.
- ARB_LSB_HIGH_PRIORITY, 1, 1 = lower index wins ties, 0 = higher index wins.
- MAX_HOLD, 0, max consecutive held cycles while another port is requesting; 0 disables preemption.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- request  input  PORTS  per-port request level.
- acknowledge  input  PORTS  per-port transfer-complete strobe (used only when ARB_BLOCK_ACK=1).
- grant  output  PORTS  registered one-hot grant.
- grant_valid  output  1  registered, high when any grant bit is set.
- grant_encoded  output  max(clog2(PORTS),1)  registered index of the granted port.

Behaviour:
- Reset (synchronous, rst high at an edge):
  - grant=0, grant_valid=0, grant_encoded=0, hold counter=0.
  - Round-robin pointer is set so the first winner is the normal fixed-priority winner.
  - Reset overrides everything else, including a held grant mid-transfer.
- Outputs are registered: request at cycle t gives grant at t+1, with no combinational path from request to grant.
- Per-edge decision, in order:
  - (1) rst.
  - (2) hold if grant_valid and the release condition is false.
  - (3) else if |request, register the winner.
  - (4) else clear grant, grant_valid and grant_encoded. grant_encoded clears to 0.
- Release condition for granted port g:
  - ARB_BLOCK=0: always released, so the grant is recomputed every cycle.
  - ARB_BLOCK=1, ARB_BLOCK_ACK=0: released when request[g]=0.
  - ARB_BLOCK_ACK=1: released when acknowledge[g]=1. request[g] dropping without ack does not release.
  - Preemption: released when MAX_HOLD>0, hold counter == MAX_HOLD-1, and request has any bit set other than g.
- Winner selection:
  - Fixed priority: the priority encoder result over request, with polarity set by ARB_LSB_HIGH_PRIORITY.
  - Round-robin (LSB high): mask = ports with index > last granted. Winner = lowest masked request if any, else lowest unmasked request. The MSB-high case is mirrored.
  - The pointer updates only when a new grant is registered.
- On a preemptive release, port g is excluded from that single arbitration, so a different port always wins. On a normal release, g may be re-granted if selected (e.g. fixed priority with request still high).
- Release plus other pending requests means the new grant appears on the very next edge, with no idle cycle.
- Hold counter:
  - Clears when a new grant is registered and on reset.
  - Increments each held cycle and saturates at MAX_HOLD-1.
  - Counts only while another port is requesting; otherwise it stays clear.
- acknowledge bits for non-granted ports are ignored. A simultaneous ack and request drop counts as a single release.
- Invariants: grant is one-hot or zero; grant_valid == |grant; grant_encoded matches grant whenever grant_valid=1.

Test Plan:
- PORTS=4, RR, BLOCK=1, ACK=0: rst, then request=4'b1111 held, each granted port drops its request one cycle after its grant → grant sequence 0001,0010,0100,1000, each one cycle after the prior release; grant_encoded 0,1,2,3.
- Fixed priority LSB, BLOCK=0: request=4'b1010 → grant=0010 next cycle. Then request=4'b1011 → grant=0001 next cycle. Then request=0 → grant_valid=0 and grant_encoded=0 next cycle.
- ARB_BLOCK_ACK=1: grant port 2, request[2] dropped → grant held. acknowledge[1]=1 → ignored. acknowledge[2]=1 at cycle t with request=4'b0001 → grant=0001 at t+1.
- MAX_HOLD=3, fixed priority: port 0 holds request high, port 3 requests from cycle 1 → port 0 granted exactly 3 cycles, then grant=1000. While port 3 holds, port 0 preempts it after 3 cycles and the two alternate.
- Reset mid-grant: grant=0100 held, rst pulsed one cycle with requests still high → outputs 0 the cycle after reset. The first post-reset grant follows the default priority (port 0 if requesting).
- Random stress, 10k cycles, random request/ack: check the invariants, that no output changes without a clock edge, and that round-robin starvation is bounded (every continuously requesting port is granted within PORTS grants).
